// File: rtl/ws2812b_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ws2812b_frame_scheduler
// Brief    : Walks a GRB framebuffer, applies global brightness and feeds
//            pixels to the WS2812B bit driver; software or auto-refresh start.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812b_frame_scheduler #(
    parameter int NUM_LEDS       = 64,
    parameter int ADDR_W         = 6,
    parameter int REFRESH_CYCLES = 400000
) (
    input  logic              clk20,
    input  logic              reset,
    input  logic              start,
    input  logic              auto_en,
    input  logic [7:0]        brightness,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [23:0]       fb_rdata,
    output logic [23:0]       drv_data,
    output logic              drv_valid,
    output logic              drv_latch,
    input  logic              drv_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int                CNT_W     = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0]  c_cnt_max = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] c_last    = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_OFFER   = 3'd3,
        S_HOLDOFF = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_index;
    logic [7:0]        r_bri;
    logic              r_hold;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pending;

    logic w_expire;
    logic w_go;
    logic w_last;

    assign w_expire = auto_en && (r_cnt == c_cnt_max);
    assign w_go     = (r_state == S_IDLE) && (start || r_pending || w_expire);
    assign w_last   = (r_index == c_last);

    // Valid must follow ready within the same cycle so it can never be raised
    // against a driver that has just dropped ready.
    assign drv_valid = (r_state == S_OFFER) && drv_ready;
    assign drv_latch = drv_valid && w_last;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(c) * (16'(b) + 16'd1);
        return 8'(p >> 8);
    endfunction

    always_ff @(posedge clk20) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_bri      <= '0;
            r_hold     <= 1'b0;
            fb_rd      <= 1'b0;
            fb_addr    <= '0;
            drv_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fb_rd      <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_bri   <= brightness;
                        r_index <= '0;
                        busy    <= 1'b1;
                        fb_rd   <= 1'b1;
                        fb_addr <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    drv_data <= {scale8(fb_rdata[23:16], r_bri),
                                 scale8(fb_rdata[15:8],  r_bri),
                                 scale8(fb_rdata[7:0],   r_bri)};
                    r_state  <= S_OFFER;
                end
                S_OFFER: begin
                    if (drv_ready) begin
                        r_hold  <= 1'b0;
                        r_state <= S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    // Two dead cycles cover the driver's registered ready echo.
                    if (!r_hold) begin
                        r_hold <= 1'b1;
                    end else if (w_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_index <= r_index + ADDR_W'(1);
                        fb_rd   <= 1'b1;
                        fb_addr <= r_index + ADDR_W'(1);
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (drv_ready) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A frame launched from IDLE consumes any pending or coincident expiry.
    always_ff @(posedge clk20) begin
        if (reset) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (!auto_en || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pending <= auto_en && !w_go && (r_pending || w_expire);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812b_frame_scheduler
// Brief    : Self-checking bench for ws2812b_frame_scheduler with a timeline
//            model, a behavioural WS2812B driver and framebuffer RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812b_frame_scheduler;

    localparam int NL    = 4;
    localparam int AW    = 2;
    localparam int RC    = 2000;
    localparam int BIT_T = 480;
    localparam int GAP_T = 600;

    logic          clk20      = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic          auto_en    = 1'b0;
    logic [7:0]    brightness = 8'd255;
    logic          fb_rd;
    logic [AW-1:0] fb_addr;
    logic [23:0]   fb_rdata   = '0;
    logic [23:0]   drv_data;
    logic          drv_valid;
    logic          drv_latch;
    logic          drv_ready;
    logic          busy;
    logic          frame_done;

    logic [23:0]   fb_mem [NL];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk20 = ~clk20;

    ws2812b_frame_scheduler #(
        .NUM_LEDS      (NL),
        .ADDR_W        (AW),
        .REFRESH_CYCLES(RC)
    ) dut (
        .clk20     (clk20),
        .reset     (reset),
        .start     (start),
        .auto_en   (auto_en),
        .brightness(brightness),
        .fb_rd     (fb_rd),
        .fb_addr   (fb_addr),
        .fb_rdata  (fb_rdata),
        .drv_data  (drv_data),
        .drv_valid (drv_valid),
        .drv_latch (drv_latch),
        .drv_ready (drv_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always @(posedge clk20) if (fb_rd) fb_rdata <= fb_mem[fb_addr];

    // Driver: ready echoes high one cycle after accept, then busy for a bit
    // time (or the latch gap after the last pixel).
    logic ready_r = 1'b1;
    logic tail    = 1'b0;
    logic stall   = 1'b0;
    int   low_cnt = 0;
    assign drv_ready = ready_r & ~stall;

    always @(posedge clk20) begin
        if (drv_valid) begin
            tail    <= 1'b1;
            low_cnt <= drv_latch ? GAP_T : BIT_T;
        end else if (tail) begin
            tail    <= 1'b0;
            ready_r <= 1'b0;
        end else if (low_cnt > 0) begin
            low_cnt <= low_cnt - 1;
            if (low_cnt == 1) ready_r <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] scale(input logic [23:0] px, input int b);
        int r, g, bl;
        r  = (int'(px[23:16]) * (b + 1)) / 256;
        g  = (int'(px[15:8])  * (b + 1)) / 256;
        bl = (int'(px[7:0])   * (b + 1)) / 256;
        return {8'(r), 8'(g), 8'(bl)};
    endfunction

    logic [23:0] cap_data[$];
    logic        cap_latch[$];
    int          done_cnt = 0;

    initial forever begin
        @(negedge clk20);
        if (drv_valid === 1'b1) begin
            cap_data.push_back(drv_data);
            cap_latch.push_back(drv_latch);
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    // Timeline model: pixel p is offered from a known cycle until the first
    // ready; fetch is two cycles before that; done follows ready in drain.
    int cyc = 0, m_pix = 0, m_offer = 0, m_drain_from = 0, m_done_at = -1;
    int m_cnt = 0, m_bri = 0;
    bit m_in = 0, m_drain = 0, m_pend = 0, chk_en = 0, exp_valid, expire;

    initial forever begin
        @(negedge clk20);
        exp_valid = m_in && !m_drain && (cyc >= m_offer) && (drv_ready === 1'b1);
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_in));
            chk("frame_done", 32'(frame_done), 32'(cyc == m_done_at));
            chk("fb_rd", 32'(fb_rd), 32'(m_in && !m_drain && cyc == m_offer - 2));
            if (fb_rd === 1'b1) chk("fb_addr", 32'(fb_addr), 32'(m_pix));
            chk("drv_valid", 32'(drv_valid), 32'(exp_valid));
            chk("drv_latch", 32'(drv_latch), 32'(exp_valid && m_pix == NL - 1));
            if (exp_valid && drv_valid === 1'b1)
                chk("drv_data", 32'(drv_data), 32'(scale(fb_mem[m_pix], m_bri)));
        end
        if (reset) begin
            m_in = 0; m_drain = 0; m_pend = 0; m_cnt = 0; m_done_at = -1; chk_en = 1;
        end else begin
            expire = auto_en && (m_cnt == RC - 1);
            if (!m_in) begin
                if (start || m_pend || expire) begin
                    m_in = 1; m_drain = 0; m_pix = 0; m_offer = cyc + 3;
                    m_bri = int'(brightness); m_pend = 0;
                end
            end else begin
                if (expire) m_pend = 1;
                if (!m_drain) begin
                    if (exp_valid) begin
                        if (m_pix == NL - 1) begin
                            m_drain = 1; m_drain_from = cyc + 3;
                        end else begin
                            m_pix++; m_offer = cyc + 5;
                        end
                    end
                end else if (cyc >= m_drain_from && drv_ready === 1'b1) begin
                    m_in = 0; m_done_at = cyc + 1;
                end
            end
            if (!auto_en) begin
                m_cnt = 0; m_pend = 0;
            end else begin
                m_cnt = expire ? 0 : m_cnt + 1;
            end
        end
        cyc++;
    end

    task automatic pulse_start();
        @(posedge clk20); #1 start = 1'b1;
        @(posedge clk20); #1 start = 1'b0;
    endtask

    task automatic clear_caps();
        cap_data.delete();
        cap_latch.delete();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin @(negedge clk20); n++; end while (frame_done !== 1'b1 && n < 20000);
        chk({tag, "_done_seen"}, 32'(frame_done), 32'd1);
    endtask

    task automatic wait_caps(input int k, input string tag);
        int n = 0;
        while (cap_data.size() < k && n < 20000) begin @(negedge clk20); n++; end
        chk({tag, "_pixels_seen"}, 32'(cap_data.size() >= k), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                               input logic [23:0] e2, input logic [23:0] e3);
        logic [23:0] e[4];
        e = '{e0, e1, e2, e3};
        repeat (2) @(negedge clk20);
        chk({tag, "_count"}, 32'(cap_data.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i), 32'(cap_data[i]), 32'(e[i]));
                chk($sformatf("%s_latch%0d", tag, i), 32'(cap_latch[i]), 32'(i == 3));
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        fb_mem = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456};
        repeat (3) @(posedge clk20);
        #1 reset = 1'b0;
        @(negedge clk20);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fb_rd", 32'(fb_rd), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_valid", 32'(drv_valid), 32'd0);
        chk("rst_data", 32'(drv_data), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);

        // Full-scale frame; a second start while busy must be dropped.
        clear_caps(); done_cnt = 0;
        pulse_start();
        repeat (20) @(posedge clk20);
        pulse_start();
        wait_done("t1");
        check_frame("t1", 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Brightness arithmetic.
        fb_mem = '{24'hFF8001, 24'hFF8001, 24'hFF8001, 24'hFF8001};
        @(posedge clk20); #1 brightness = 8'd127; clear_caps();
        pulse_start();
        wait_done("t2a");
        check_frame("t2a", 24'h7F4000, 24'h7F4000, 24'h7F4000, 24'h7F4000);
        @(posedge clk20); #1 brightness = 8'd0; clear_caps();
        pulse_start();
        wait_done("t2b");
        check_frame("t2b", 24'h000000, 24'h000000, 24'h000000, 24'h000000);

        // Brightness change mid-frame applies only to the next frame.
        fb_mem = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456};
        @(posedge clk20); #1 brightness = 8'd255; clear_caps();
        pulse_start();
        wait_caps(1, "t3");
        @(posedge clk20); #1 brightness = 8'd0;
        wait_done("t3a");
        check_frame("t3a", 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);
        clear_caps();
        pulse_start();
        wait_done("t3b");
        check_frame("t3b", 24'h000000, 24'h000000, 24'h000000, 24'h000000);

        // Driver not ready for 50 cycles at the first offer.
        @(posedge clk20); #1 brightness = 8'd255; stall = 1'b1; clear_caps();
        pulse_start();
        repeat (50) @(negedge clk20);
        chk("t4_stall_no_valid", 32'(cap_data.size()), 32'd0);
        chk("t4_stall_busy", 32'(busy), 32'd1);
        @(posedge clk20); #1 stall = 1'b0;
        wait_done("t4");
        check_frame("t4", 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);

        // Auto-refresh: frame outlasts the period, next frame follows at once.
        clear_caps(); done_cnt = 0;
        @(posedge clk20); #1 auto_en = 1'b1;
        wait_done("t5a");
        chk("t5_gap_busy_low", 32'(busy), 32'd0);
        @(negedge clk20);
        chk("t5_restart_busy", 32'(busy), 32'd1);
        chk("t5_restart_fb_rd", 32'(fb_rd), 32'd1);
        chk("t5_restart_addr", 32'(fb_addr), 32'd0);
        chk("t5a_count", 32'(cap_data.size()), 32'd4);
        clear_caps();
        repeat (30) @(posedge clk20);
        pulse_start();
        @(posedge clk20); #1 auto_en = 1'b0;
        wait_done("t5b");
        repeat (50) @(negedge clk20);
        chk("t5_idle_after", 32'(busy), 32'd0);
        chk("t5_done_cnt", 32'(done_cnt), 32'd2);
        chk("t5b_count", 32'(cap_data.size()), 32'd4);

        // Reset while fetching pixel 2.
        clear_caps(); done_cnt = 0;
        pulse_start();
        wait_caps(2, "t6");
        repeat (3) @(posedge clk20);
        #1 reset = 1'b1;
        @(posedge clk20); #1 reset = 1'b0;
        @(negedge clk20);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_fb_rd", 32'(fb_rd), 32'd0);
        chk("t6_fb_addr", 32'(fb_addr), 32'd0);
        chk("t6_valid", 32'(drv_valid), 32'd0);
        chk("t6_latch", 32'(drv_latch), 32'd0);
        chk("t6_data", 32'(drv_data), 32'd0);
        repeat (100) @(negedge clk20);
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        clear_caps();
        pulse_start();
        wait_done("t6b");
        check_frame("t6b", 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h123456);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
